// File: rtl/shiftreg_pkg.sv
// Shared types and register map for the 74HC595 serial output controller.
package shiftreg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_LATCH
    } state_t;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_PEND_BIT = 1;

    function automatic logic [31:0] status_word(input logic busy, input logic pend);
        logic [31:0] w;
        w                = '0;
        w[STAT_BUSY_BIT] = busy;
        w[STAT_PEND_BIT] = pend;
        return w;
    endfunction

endpackage

// File: rtl/shiftreg_out_ctl_if.sv
// Avalon-MM slave bus bundle for the serial output controller.
interface shiftreg_out_ctl_if;
    logic        avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata
    );
endinterface

// File: rtl/shiftreg_tick_gen.sv
// Half-period timer: counts CLK_DIV-1 down to 0, ticks on 0, reloads on tick or restart.
module shiftreg_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= LOAD;
        end else if (restart || count_reg == '0) begin
            count_reg <= LOAD;
        end else begin
            count_reg <= count_reg - CW'(1);
        end
    end

    assign tick = (count_reg == '0);

endmodule

// File: rtl/shiftreg_out_ctl.sv
// Avalon-MM slave that shifts a written word MSB-first into chained 74HC595s and pulses the latch.
// Optional periodic re-send of the last word: define SHIFTREG_AUTO_REFRESH_EN.
module shiftreg_out_ctl
    import shiftreg_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4,
    parameter int REFRESH = 0
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    shiftreg_out_ctl_if.slave  avs,
    output logic               shiftreg_clk,
    output logic               shiftreg_data,
    output logic               shiftreg_latch
);
    localparam int            BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] MSB_IDX = BW'(WIDTH - 1);

    state_t           state_reg;
    logic [BW-1:0]    bit_idx_reg;
    logic [BW-1:0]    bit_idx_next;
    logic [WIDTH-1:0] shadow_reg;
    logic [WIDTH-1:0] pending_reg;
    logic             pend_v_reg;
    logic             sclk_reg;
    logic             sdata_reg;
    logic             latch_reg;
    logic [31:0]      readdata_reg;

    logic             tick;
    logic             busy;
    logic             wr_data;
    logic [WIDTH-1:0] wr_word;
    logic             refresh_due;
    logic             wdata_unused;

    assign busy         = (state_reg != ST_IDLE);
    assign wr_data      = avs.avs_write && (avs.avs_address == ADDR_DATA);
    assign wr_word      = avs.avs_writedata[WIDTH-1:0];
    assign bit_idx_next = bit_idx_reg - BW'(1);
    assign wdata_unused = ^avs.avs_writedata;

    shiftreg_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .restart (!busy),
        .tick    (tick)
    );

`ifdef SHIFTREG_AUTO_REFRESH_EN
    localparam logic [31:0] REFRESH_LOAD = (REFRESH > 0) ? 32'(REFRESH - 1) : 32'd0;

    logic [31:0] refresh_cnt_reg;

    // Reloads at every transfer end, frozen while busy, counts down only in IDLE.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            refresh_cnt_reg <= REFRESH_LOAD;
        end else if (state_reg == ST_LATCH && tick) begin
            refresh_cnt_reg <= REFRESH_LOAD;
        end else if (state_reg == ST_IDLE && refresh_cnt_reg != '0) begin
            refresh_cnt_reg <= refresh_cnt_reg - 32'd1;
        end
    end

    assign refresh_due = (state_reg == ST_IDLE) && !pend_v_reg && (refresh_cnt_reg == '0);
`else
    logic refresh_unused;
    assign refresh_unused = (REFRESH != 0);
    assign refresh_due    = 1'b0;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_reg    <= ST_IDLE;
            bit_idx_reg  <= '0;
            shadow_reg   <= '0;
            pending_reg  <= '0;
            pend_v_reg   <= 1'b0;
            sclk_reg     <= 1'b0;
            sdata_reg    <= 1'b0;
            latch_reg    <= 1'b0;
            readdata_reg <= '0;
        end else begin
            if (avs.avs_read) begin
                readdata_reg <= (avs.avs_address == ADDR_STATUS) ?
                                status_word(busy, pend_v_reg) : 32'(shadow_reg);
            end

            if (wr_data && busy) begin
                pending_reg <= wr_word;
                pend_v_reg  <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (wr_data) begin
                        shadow_reg  <= wr_word;
                        state_reg   <= ST_LOW;
                        bit_idx_reg <= MSB_IDX;
                        sdata_reg   <= wr_word[WIDTH-1];
                    end else if (refresh_due) begin
                        state_reg   <= ST_LOW;
                        bit_idx_reg <= MSB_IDX;
                        sdata_reg   <= shadow_reg[WIDTH-1];
                    end
                end

                ST_LOW: begin
                    if (tick) begin
                        state_reg <= ST_HIGH;
                        sclk_reg  <= 1'b1;
                    end
                end

                ST_HIGH: begin
                    if (tick) begin
                        sclk_reg <= 1'b0;
                        if (bit_idx_reg == '0) begin
                            state_reg <= ST_LATCH;
                            latch_reg <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_idx_next;
                            sdata_reg   <= shadow_reg[bit_idx_next];
                            state_reg   <= ST_LOW;
                        end
                    end
                end

                ST_LATCH: begin
                    if (tick) begin
                        latch_reg   <= 1'b0;
                        bit_idx_reg <= MSB_IDX;
                        // A write landing on the final LATCH cycle must be sent exactly once.
                        if (wr_data && !pend_v_reg) begin
                            shadow_reg <= wr_word;
                            pend_v_reg <= 1'b0;
                            sdata_reg  <= wr_word[WIDTH-1];
                            state_reg  <= ST_LOW;
                        end else if (pend_v_reg) begin
                            shadow_reg <= pending_reg;
                            pend_v_reg <= wr_data;
                            sdata_reg  <= pending_reg[WIDTH-1];
                            state_reg  <= ST_LOW;
                        end else begin
                            sdata_reg <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign avs.avs_readdata = readdata_reg;
    assign shiftreg_clk     = sclk_reg;
    assign shiftreg_data    = sdata_reg;
    assign shiftreg_latch   = latch_reg;

endmodule

// File: tb/tb_shiftreg_out_ctl.sv
// Scoreboard bench for shiftreg_out_ctl with a behavioural 74HC595 chain model.
`timescale 1ns/1ps
module tb_shiftreg_out_ctl;
    import shiftreg_pkg::*;

    localparam int WIDTH   = 16;
    localparam int CLK_DIV = 4;
    localparam int XFER    = 2 * WIDTH * CLK_DIV + CLK_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic sclk, sdata, slatch;

    shiftreg_out_ctl_if bus();

    shiftreg_out_ctl #(
        .WIDTH   (WIDTH),
        .CLK_DIV (CLK_DIV),
        .REFRESH (500)
    ) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .avs            (bus),
        .shiftreg_clk   (sclk),
        .shiftreg_data  (sdata),
        .shiftreg_latch (slatch)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_q[$];
    logic [31:0] rd_q[$];
    string       rd_name_q[$];

    // 595 chain model: shift on SRCLK rise, copy to outputs on RCLK rise
    logic [15:0] sr_shift  = '0;
    logic [15:0] sr_par    = '0;
    int          shift_cnt = 0;

    always @(posedge sclk) begin
        sr_shift = {sr_shift[14:0], sdata};
        shift_cnt++;
    end

    always @(posedge slatch) sr_par = sr_shift;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: read responses and latch pulses
    logic        latch_prev = 1'b0;
    logic        sclk_prev  = 1'b0;
    logic        rd_fire_d  = 1'b0;
    logic        gap_armed  = 1'b0;
    int          latch_len     = 0;
    int          latch_pulses  = 0;
    int          cyc           = 0;
    int          last_fall_cyc = 0;
    int          rise_gap      = -1;
    logic [31:0] mon_exp;
    string       mon_name;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rd_fire_d <= bus.avs_read && rst_n;
    end

    always @(negedge clk) begin
        if (rd_fire_d) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got 0x%08h expected no response", bus.avs_readdata);
            end else begin
                mon_exp  = rd_q.pop_front();
                mon_name = rd_name_q.pop_front();
                cmp(mon_name, bus.avs_readdata, mon_exp);
            end
        end
        if (slatch) latch_len++;
        if (latch_prev && !slatch) begin
            latch_pulses++;
            cmp("latch_width", 32'(latch_len), 32'(CLK_DIV));
            cmp("shift_edges", 32'(shift_cnt), 32'(WIDTH));
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL latch_unexpected: got 0x%04h expected no latch", sr_par);
            end else begin
                cmp("parallel_out", 32'(sr_par), 32'(exp_q.pop_front()));
            end
            latch_len     = 0;
            shift_cnt     = 0;
            last_fall_cyc = cyc;
            gap_armed     = 1'b1;
        end
        if (sclk && !sclk_prev && gap_armed) begin
            rise_gap  = cyc - last_fall_cyc;
            gap_armed = 1'b0;
        end
        latch_prev = slatch;
        sclk_prev  = sclk;
    end

    task automatic bus_write(input logic addr, input logic [31:0] data);
        bus.avs_address   = addr;
        bus.avs_writedata = data;
        bus.avs_write     = 1'b1;
        @(posedge clk);
        #1;
        bus.avs_write = 1'b0;
        $display("write addr=%0d data=0x%08h", addr, data);
    endtask

    task automatic bus_read(input logic addr, input logic [31:0] exp, input string nm);
        rd_q.push_back(exp);
        rd_name_q.push_back(nm);
        bus.avs_address = addr;
        bus.avs_read    = 1'b1;
        @(posedge clk);
        #1;
        bus.avs_read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int k;
        bus.avs_address   = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        bus.avs_read      = 1'b0;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Reset state
        cmp("rst_sclk",  32'(sclk),   32'd0);
        cmp("rst_sdata", 32'(sdata),  32'd0);
        cmp("rst_latch", 32'(slatch), 32'd0);
        bus_read(ADDR_STATUS, 32'h0, "rst_status");
        bus_read(ADDR_DATA,   32'h0, "rst_data");
        idle(2);

        // Single write with a per-cycle STATUS poll across the busy window
        base = latch_pulses;
        exp_q.push_back(16'hA5C3);
        bus_write(ADDR_DATA, 32'h0000A5C3);
        for (int i = 0; i < XFER + 8; i++)
            bus_read(ADDR_STATUS, (i < XFER) ? 32'h1 : 32'h0, "busy_window");
        bus_read(ADDR_DATA, 32'h0000A5C3, "single_data");
        idle(4);
        cmp("single_pulses", 32'(latch_pulses - base), 32'd1);
        cmp("single_queue",  32'(exp_q.size()), 32'd0);

        // Back-to-back: 0x2222 is overwritten by 0x3333 while pending
        base = latch_pulses;
        exp_q.push_back(16'h1111);
        bus_write(ADDR_DATA, 32'h00001111);
        idle(20);
        bus_write(ADDR_DATA, 32'h00002222);
        idle(20);
        exp_q.push_back(16'h3333);
        bus_write(ADDR_DATA, 32'h00003333);
        bus_read(ADDR_STATUS, 32'h3, "mid_status");
        bus_read(ADDR_DATA,   32'h00001111, "mid_data");
        idle(2 * XFER + 10);
        cmp("b2b_pulses", 32'(latch_pulses - base), 32'd2);
        cmp("b2b_gap",    32'(rise_gap), 32'(CLK_DIV));
        cmp("b2b_queue",  32'(exp_q.size()), 32'd0);
        bus_read(ADDR_STATUS, 32'h0, "post_status");
        bus_read(ADDR_DATA,   32'h00003333, "post_data");
        idle(2);

        // Write sampled on the very cycle the transfer ends
        base = latch_pulses;
        exp_q.push_back(16'h0F0F);
        bus_write(ADDR_DATA, 32'h00000F0F);
        idle(XFER - 1);
        exp_q.push_back(16'h7E81);
        bus_write(ADDR_DATA, 32'h00007E81);
        idle(2 * XFER + 10);
        cmp("edge_pulses", 32'(latch_pulses - base), 32'd2);
        cmp("edge_queue",  32'(exp_q.size()), 32'd0);

        // Reset during the HIGH phase of bit 7 (0xBEEF bit 7 is 1)
        base = latch_pulses;
        bus_write(ADDR_DATA, 32'h0000BEEF);
        k = 0;
        while (shift_cnt < 8 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        cmp("reach_bit7", 32'(shift_cnt), 32'd8);
        idle(9);
        cmp("pre_rst_sclk",  32'(sclk),  32'd1);
        cmp("pre_rst_sdata", 32'(sdata), 32'd1);
        rst_n = 1'b0;
        #1;
        cmp("rst_mid_sclk",  32'(sclk),   32'd0);
        cmp("rst_mid_sdata", 32'(sdata),  32'd0);
        cmp("rst_mid_latch", 32'(slatch), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        cmp("rst_no_latch", 32'(latch_pulses - base), 32'd0);
        cmp("rst_par_kept", 32'(sr_par), 32'h00007E81);
        shift_cnt = 0;
        rst_n     = 1'b1;
        idle(2);
        bus_read(ADDR_STATUS, 32'h0, "rst_rel_status");
        bus_read(ADDR_DATA,   32'h0, "rst_rel_data");
        idle(2);

        // Upper bits above WIDTH are dropped
        base = latch_pulses;
        exp_q.push_back(16'h0001);
        bus_write(ADDR_DATA, 32'hFFFF0001);
        idle(XFER + 10);
        bus_read(ADDR_DATA,   32'h00000001, "bound_data");
        bus_read(ADDR_STATUS, 32'h0, "bound_status");
        cmp("bound_pulses", 32'(latch_pulses - base), 32'd1);
        cmp("bound_queue",  32'(exp_q.size()), 32'd0);

        // STATUS writes have no effect
        base = latch_pulses;
        bus_write(ADDR_STATUS, 32'h00001234);
        idle(20);
        bus_read(ADDR_STATUS, 32'h0, "stwr_status");
        bus_read(ADDR_DATA,   32'h00000001, "stwr_data");
        idle(3);
        cmp("stwr_pulses", 32'(latch_pulses - base), 32'd0);
        cmp("rd_queue", 32'(rd_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
